// File: rtl/ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave
// AHB slave backed by a flop-array word memory. Pipelined address/data phases,
// WAIT_STATES zero-ready cycles per OKAY data phase, two-cycle ERROR response.
// Little-endian byte lanes.
//
// Ports
//   hclk       in   1   bus clock, all state on rising edge
//   hreset     in   1   asynchronous active-high reset
//   hsel       in   1   slave select from decoder
//   haddr      in   32  byte address (address phase)
//   hwrite     in   1   0 = READ, 1 = WRITE
//   htrans     in   2   IDLE / BUSY / NONSEQ / SEQ
//   hsize      in   3   transfer size (BYTE / HWORD / WORD, larger sizes error)
//   hburst     in   3   burst type, informational only
//   hwdata     in   32  write data (data phase)
//   hready     in   1   bus-wide ready
//   hreadyout  out  1   this slave's ready
//   hrdata     out  32  read data (data phase)
//   hresp      out  2   OKAY / ERROR
// ----------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic [31:0] hrdata,
    output logic [1:0]  hresp
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 3;
    localparam logic [32:0] BYTES = 33'(DEPTH) * 33'd4;

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] SIZE_HWORD   = 3'd1;
    localparam logic [2:0] SIZE_WORD    = 3'd2;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // State and latched address-phase information
    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic               dp_valid;
    logic               dp_valid_n;
    logic               write_q;
    logic [1:0]         size_q;
    logic [1:0]         addr_q;
    logic [IDX_W-1:0]   idx_q;

    logic               ready_n;
    logic [1:0]         resp_n;
    logic [31:0]        rdata_n;
    logic               latch_c;

    logic [31:0]        mem [DEPTH];

    logic               accept_c;
    logic               err_c;
    logic               phase_end_c;
    logic               commit_c;
    logic [3:0]         be_c;
    logic [31:0]        wmerge_c;
    logic [IDX_W-1:0]   rd_idx_c;
    logic [31:0]        rd_word_c;

    // Burst type is not needed: the master supplies every beat address.
    logic               unused_inputs;
    assign unused_inputs = ^hburst;

    // Address phase is taken only while our own data phase is finishing (or idle).
    assign accept_c = hready & hreadyout & hsel &
                      ((htrans == TRANS_NONSEQ) | (htrans == TRANS_SEQ));

    // Out of range, oversize or misaligned accesses answer ERROR.
    assign err_c = ({1'b0, haddr} >= BYTES) |
                   (hsize > SIZE_WORD) |
                   ((hsize == SIZE_HWORD) & haddr[0]) |
                   ((hsize == SIZE_WORD) & (haddr[1:0] != 2'b00));

    // The current data phase finishes at the coming edge.
    assign phase_end_c = (state == ST_IDLE) | (state == ST_ERR2) |
                         ((state == ST_WAIT) & (cnt == '0));

    assign commit_c = dp_valid & write_q & phase_end_c;
    assign rd_idx_c = haddr[IDX_W+1:2];

    // Byte-lane enables of the latched write
    always_comb begin
        be_c = 4'b1111;
        case (size_q)
            2'd0:    be_c = 4'b0001 << addr_q;
            2'd1:    be_c = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be_c = 4'b1111;
        endcase
    end

    // Word as it will look after the pending write commits
    always_comb begin
        wmerge_c = mem[idx_q];
        for (int n = 0; n < 4; n++) begin
            if (be_c[n]) begin
                wmerge_c[8*n +: 8] = hwdata[8*n +: 8];
            end
        end
    end

    // Read data forwarded from a write committing on the same edge
    always_comb begin
        rd_word_c = mem[rd_idx_c];
        if (commit_c && (idx_q == rd_idx_c)) begin
            rd_word_c = wmerge_c;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_n    = ST_IDLE;
        cnt_n      = cnt;
        dp_valid_n = 1'b0;
        ready_n    = 1'b1;
        resp_n     = RESP_OKAY;
        rdata_n    = '0;
        latch_c    = 1'b0;

        // Behaviour when the current data phase ends this cycle
        if (accept_c) begin
            if (err_c) begin
                state_n = ST_ERR1;
                ready_n = 1'b0;
                resp_n  = RESP_ERROR;
            end else begin
                latch_c    = 1'b1;
                dp_valid_n = 1'b1;
                rdata_n    = hwrite ? 32'h0 : rd_word_c;
                if (WAIT_STATES != 0) begin
                    state_n = ST_WAIT;
                    cnt_n   = CNT_W'(WAIT_STATES);
                    ready_n = 1'b0;
                end
            end
        end

        case (state)
            ST_WAIT: begin
                if (cnt != '0) begin
                    state_n    = ST_WAIT;
                    cnt_n      = cnt - CNT_W'(1);
                    dp_valid_n = dp_valid;
                    ready_n    = (cnt == CNT_W'(1));
                    resp_n     = RESP_OKAY;
                    rdata_n    = hrdata;
                    latch_c    = 1'b0;
                end
            end
            ST_ERR1: begin
                state_n    = ST_ERR2;
                dp_valid_n = 1'b0;
                ready_n    = 1'b1;
                resp_n     = RESP_ERROR;
                rdata_n    = '0;
                latch_c    = 1'b0;
            end
            default: ;
        endcase
    end

    // State, address-phase capture and output registers
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dp_valid  <= 1'b0;
            write_q   <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            hreadyout <= 1'b1;
            hresp     <= RESP_OKAY;
            hrdata    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dp_valid  <= dp_valid_n;
            hreadyout <= ready_n;
            hresp     <= resp_n;
            hrdata    <= rdata_n;
            if (latch_c) begin
                write_q <= hwrite;
                size_q  <= hsize[1:0];
                addr_q  <= haddr[1:0];
                idx_q   <= rd_idx_c;
            end
        end
    end

    // Memory array; an uncommitted write is lost on reset
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit_c) begin
            mem[idx_q] <= wmerge_c;
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_ahb_sram_slave
// Two slaves (WAIT_STATES 0 and 2) run the same command stream, each with its
// own master pacing on its own hreadyout. A transaction-level model of the
// memory and of the current data phase predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_ahb_sram_slave;

    localparam int NI = 2;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned WS0 = 0;
    localparam int unsigned WS1 = 2;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } cmd_t;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel_v   [NI];
    logic [31:0] haddr_v  [NI];
    logic        hwrite_v [NI];
    logic [1:0]  htrans_v [NI];
    logic [2:0]  hsize_v  [NI];
    logic [2:0]  hburst_v [NI];
    logic [31:0] hwdata_v [NI];

    logic        rdy0, rdy1;
    logic [31:0] rd0, rd1;
    logic [1:0]  rs0, rs1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: memory image and the data phase currently on the bus
    logic [31:0] ref_mem [NI][DEPTH];
    int          ph_kind [NI];   // 0 none, 1 OKAY transfer, 2 ERROR
    int          ph_el   [NI];   // cycles already spent in this data phase
    logic        ph_wr   [NI];
    int          ph_idx  [NI];
    logic [3:0]  ph_be   [NI];

    // Observed statistics for literal checks
    int          lowcnt  [NI];
    int          errcyc  [NI];
    logic [31:0] last_rd [NI];

    cmd_t cmds[$];

    always #5 hclk = ~hclk;

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_v[0]), .haddr(haddr_v[0]),
        .hwrite(hwrite_v[0]), .htrans(htrans_v[0]), .hsize(hsize_v[0]),
        .hburst(hburst_v[0]), .hwdata(hwdata_v[0]), .hready(rdy0),
        .hreadyout(rdy0), .hrdata(rd0), .hresp(rs0)
    );

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_v[1]), .haddr(haddr_v[1]),
        .hwrite(hwrite_v[1]), .htrans(htrans_v[1]), .hsize(hsize_v[1]),
        .hburst(hburst_v[1]), .hwdata(hwdata_v[1]), .hready(rdy1),
        .hreadyout(rdy1), .hrdata(rd1), .hresp(rs1)
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? int'(WS0) : int'(WS1);
    endfunction

    // Expected ready for the current cycle from the data-phase description
    function automatic logic exp_ready(input int k);
        if (ph_kind[k] == 1) return (ph_el[k] == wait_of(k));
        if (ph_kind[k] == 2) return (ph_el[k] == 1);
        return 1'b1;
    endfunction

    // Model update at each rising edge
    always @(posedge hclk) begin
        for (int k = 0; k < NI; k++) begin
            if (hreset) begin
                ph_kind[k] = 0;
                ph_el[k]   = 0;
                for (int j = 0; j < DEPTH; j++) ref_mem[k][j] = 32'h0;
            end else if (exp_ready(k)) begin
                if (ph_kind[k] == 1 && ph_wr[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ph_be[k][b]) ref_mem[k][ph_idx[k]][8*b +: 8] = hwdata_v[k][8*b +: 8];
                    end
                end
                ph_kind[k] = 0;
                ph_el[k]   = 0;
                if (hsel_v[k] && htrans_v[k] >= 2'd2) begin
                    logic [31:0] a;
                    int unsigned s;
                    logic bad;
                    a = haddr_v[k];
                    s = int'(hsize_v[k]);
                    bad = (a >= DEPTH * 4) || (s > 2) || (s == 1 && a % 2 != 0) || (s == 2 && a % 4 != 0);
                    if (bad) begin
                        ph_kind[k] = 2;
                    end else begin
                        ph_kind[k] = 1;
                        ph_wr[k]   = hwrite_v[k];
                        ph_idx[k]  = int'(a / 4);
                        if (s == 0) ph_be[k] = 4'(1 << (a % 4));
                        else if (s == 1) ph_be[k] = 4'(3 << (a % 4));
                        else ph_be[k] = 4'hF;
                    end
                end
            end else begin
                ph_el[k]++;
            end
        end
    end

    // Compare process on the falling edge
    always @(negedge hclk) begin
        for (int k = 0; k < NI; k++) begin
            logic        ar, er;
            logic [31:0] ad, ed;
            logic [1:0]  ap, ep;
            ar = (k == 0) ? rdy0 : rdy1;
            ad = (k == 0) ? rd0 : rd1;
            ap = (k == 0) ? rs0 : rs1;
            if (hreset) begin
                er = 1'b1; ep = 2'b00; ed = 32'h0;
            end else begin
                er = exp_ready(k);
                ep = (ph_kind[k] == 2) ? 2'b01 : 2'b00;
                ed = (ph_kind[k] == 1 && !ph_wr[k]) ? ref_mem[k][ph_idx[k]] : 32'h0;
            end
            chk("hreadyout", k, 32'(ar), 32'(er));
            chk("hresp", k, 32'(ap), 32'(ep));
            chk("hrdata", k, ad, ed);
            if (!hreset) begin
                if (!ar) lowcnt[k]++;
                if (ap == 2'b01) errcyc[k]++;
                if (ph_kind[k] == 1 && !ph_wr[k] && er) last_rd[k] = ad;
            end
        end
    end

    function automatic cmd_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                                input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        cmd_t c;
        c.sel = sel; c.trans = tr; c.write = wr; c.addr = a; c.size = sz;
        c.burst = 3'($urandom_range(0, 7)); c.wdata = wd;
        return c;
    endfunction

    task automatic push_rd(input logic [31:0] a, input logic [2:0] sz);
        cmds.push_back(mk(1'b1, 2'b10, 1'b0, a, sz, $urandom));
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        cmds.push_back(mk(1'b1, 2'b10, 1'b1, a, sz, d));
    endtask

    task automatic push_idle();
        cmds.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0, 3'd2, $urandom));
    endtask

    task automatic present(input int k, input cmd_t c);
        hsel_v[k]   = c.sel;
        htrans_v[k] = c.trans;
        hwrite_v[k] = c.write;
        haddr_v[k]  = c.addr;
        hsize_v[k]  = c.size;
        hburst_v[k] = c.burst;
    endtask

    task automatic clr_stats();
        for (int k = 0; k < NI; k++) begin
            lowcnt[k] = 0; errcyc[k] = 0; last_rd[k] = 32'hFFFF_FFFF;
        end
    endtask

    // Drive the command list into both slaves; entered and left at posedge+1
    task automatic run_cmds();
        int   idx [NI];
        logic rs  [NI];
        int   guard;
        guard = 0;
        push_idle();
        push_idle();
        for (int k = 0; k < NI; k++) begin
            idx[k] = 0;
            present(k, cmds[0]);
        end
        while ((idx[0] < cmds.size() || idx[1] < cmds.size()) && guard < 5000) begin
            @(negedge hclk);
            rs[0] = rdy0;
            rs[1] = rdy1;
            @(posedge hclk);
            #1;
            for (int k = 0; k < NI; k++) begin
                if (idx[k] < cmds.size() && rs[k]) begin
                    hwdata_v[k] = cmds[idx[k]].wdata;
                    idx[k]++;
                    if (idx[k] < cmds.size()) present(k, cmds[idx[k]]);
                end
            end
            guard++;
        end
        chk("driver_bound", 0, 32'(guard < 5000), 32'h1);
        cmds.delete();
    endtask

    task automatic gen_random(input int n);
        int unsigned r, e;
        logic [2:0]  s;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 15);
            s = 3'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 127));
            a = a & ~((32'd1 << s) - 32'd1);
            if (r == 0) begin
                push_idle();
            end else if (r == 1) begin
                cmds.push_back(mk(1'b1, 2'b01, 1'($urandom), a, s, $urandom));
            end else if (r == 2) begin
                cmds.push_back(mk(1'b0, 2'b10, 1'($urandom), a, s, $urandom));
            end else if (r == 3) begin
                e = $urandom_range(0, 2);
                if (e == 0) begin
                    a = 32'h400 + 32'($urandom_range(0, 1023)) * 4;
                    if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC;
                    s = 3'd2;
                end else if (e == 1) begin
                    s = 3'd2;
                    a = a | 32'($urandom_range(1, 3));
                end else begin
                    s = 3'($urandom_range(3, 7));
                end
                cmds.push_back(mk(1'b1, 2'b10 | 2'($urandom_range(0, 1)), 1'($urandom), a, s, $urandom));
            end else begin
                cmds.push_back(mk(1'b1, 2'b10 | 2'($urandom_range(0, 1)), 1'($urandom), a, s, $urandom));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            present(k, mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0));
            hwdata_v[k] = 32'h0;
        end
        clr_stats();
        repeat (2) @(posedge hclk);
        #1;
        chk("reset_ready", 0, 32'(rdy0), 32'h1);
        chk("reset_ready", 1, 32'(rdy1), 32'h1);
        chk("reset_resp", 0, 32'(rs0), 32'h0);
        chk("reset_resp", 1, 32'(rs1), 32'h0);
        chk("reset_rdata", 0, rd0, 32'h0);
        chk("reset_rdata", 1, rd1, 32'h0);
        hreset = 1'b0;

        // Read of cleared memory
        clr_stats();
        push_rd(32'h10, 3'd2);
        run_cmds();
        for (int k = 0; k < NI; k++) chk("lit_rd_0x10", k, last_rd[k], 32'h0000_0000);

        // Write then back-to-back read
        clr_stats();
        push_wr(32'h04, 3'd2, 32'hDEAD_BEEF);
        push_rd(32'h04, 3'd2);
        run_cmds();
        for (int k = 0; k < NI; k++) chk("lit_word_wr", k, last_rd[k], 32'hDEAD_BEEF);
        chk("lit_no_wait", 0, 32'(lowcnt[0]), 32'd0);

        // Byte and halfword lanes
        clr_stats();
        push_wr(32'h05, 3'd0, 32'h0000_AB00);
        push_rd(32'h04, 3'd2);
        run_cmds();
        for (int k = 0; k < NI; k++) chk("lit_byte_wr", k, last_rd[k], 32'hDEAD_ABEF);
        clr_stats();
        push_wr(32'h06, 3'd1, 32'h1234_0000);
        push_rd(32'h04, 3'd2);
        run_cmds();
        for (int k = 0; k < NI; k++) chk("lit_hword_wr", k, last_rd[k], 32'h1234_ABEF);

        // INCR4 read with a BUSY after beat 2
        clr_stats();
        push_wr(32'h2C, 3'd2, 32'h55AA_33CC);
        cmds.push_back(mk(1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'h0));
        cmds.push_back(mk(1'b1, 2'b11, 1'b0, 32'h24, 3'd2, 32'h0));
        cmds.push_back(mk(1'b1, 2'b01, 1'b0, 32'h28, 3'd2, 32'h0));
        cmds.push_back(mk(1'b1, 2'b11, 1'b0, 32'h28, 3'd2, 32'h0));
        cmds.push_back(mk(1'b1, 2'b11, 1'b0, 32'h2C, 3'd2, 32'h0));
        run_cmds();
        for (int k = 0; k < NI; k++) chk("lit_burst_rd", k, last_rd[k], 32'h55AA_33CC);
        chk("lit_burst_low", 0, 32'(lowcnt[0]), 32'd0);
        chk("lit_burst_low", 1, 32'(lowcnt[1]), 32'd10);

        // Error responses leave memory untouched
        clr_stats();
        push_rd(32'h400, 3'd2);
        push_wr(32'h02, 3'd2, 32'hFFFF_FFFF);
        push_wr(32'h00, 3'd3, 32'hFFFF_FFFF);
        push_rd(32'h00, 3'd2);
        run_cmds();
        for (int k = 0; k < NI; k++) begin
            chk("lit_err_rd", k, last_rd[k], 32'h0);
            chk("lit_err_cycles", k, 32'(errcyc[k]), 32'd6);
        end
        chk("lit_err_low", 0, 32'(lowcnt[0]), 32'd3);
        chk("lit_err_low", 1, 32'(lowcnt[1]), 32'd5);

        // Randomized traffic
        gen_random(400);
        run_cmds();

        // Reset during the data phase of a write to 0x08
        for (int k = 0; k < NI; k++) present(k, mk(1'b1, 2'b10, 1'b1, 32'h08, 3'd2, 32'h0));
        @(posedge hclk);
        #1;
        for (int k = 0; k < NI; k++) begin
            present(k, mk(1'b1, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0));
            hwdata_v[k] = 32'hCAFE_F00D;
        end
        chk("pre_reset_wait", 1, 32'(rdy1), 32'h0);
        #2;
        hreset = 1'b1;
        #1;
        chk("async_ready", 0, 32'(rdy0), 32'h1);
        chk("async_ready", 1, 32'(rdy1), 32'h1);
        chk("async_resp", 1, 32'(rs1), 32'h0);
        repeat (2) @(posedge hclk);
        #1;
        hreset = 1'b0;
        clr_stats();
        push_rd(32'h08, 3'd2);
        run_cmds();
        for (int k = 0; k < NI; k++) chk("lit_reset_drop", k, last_rd[k], 32'h0);
        clr_stats();
        push_rd(32'h04, 3'd2);
        run_cmds();
        for (int k = 0; k < NI; k++) chk("lit_reset_clear", k, last_rd[k], 32'h0);

        repeat (2) @(posedge hclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
